// File: rtl/mul_int_arb_if.sv
// -----------------------------------------------------------------------------
// mul_int_arb_if
// Per-requester channel of the shared-multiplier arbiter. It bundles the
// operand request handshake and the product response handshake of one
// requester.
//   req_valid/req_ready : operand pair handshake (requester -> arbiter)
//   req_a/req_b         : operands, DATA_WIDTH bits each
//   req_signed          : 1 = two's-complement multiply, 0 = unsigned
//   rsp_valid/rsp_ready : product handshake (arbiter -> requester)
//   rsp_data            : product, 2*DATA_WIDTH bits, in request order
// Modports: master = requester side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface mul_int_arb_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      req_valid;
    logic                      req_ready;
    logic [DATA_WIDTH-1:0]     req_a;
    logic [DATA_WIDTH-1:0]     req_b;
    logic                      req_signed;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [2*DATA_WIDTH-1:0]   rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_signed, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_signed, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mul_int_arb.sv
// -----------------------------------------------------------------------------
// mul_int_arb
// Shares one external pipelined multiplier between two requesters. Requests are
// granted round-robin, each issued operation is tracked by a shadow pipeline of
// {valid, requester id} running in lockstep with the multiplier, and every
// returning product is steered into that requester's result FIFO. Per-requester
// credits (outstanding operations) cap issue so a FIFO slot always exists and
// the multiplier never has to stall.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ch0, ch1            : requester channels (mul_int_arb_if.slave)
//   mul_valid           : one-cycle issue strobe to the multiplier
//   mul_src0/mul_src1   : registered operands to the multiplier
//   mul_signed          : registered signedness to the multiplier
//   mul_res             : product, valid LATENCY cycles after mul_valid
// -----------------------------------------------------------------------------
module mul_int_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    mul_int_arb_if.slave            ch0,
    mul_int_arb_if.slave            ch1,
    output logic                    mul_valid,
    output logic [DATA_WIDTH-1:0]   mul_src0,
    output logic [DATA_WIDTH-1:0]   mul_src1,
    output logic                    mul_signed,
    input  logic [2*DATA_WIDTH-1:0] mul_res
);
    localparam int PW = 2 * DATA_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Channel signals gathered into vectors indexed by requester id
    logic [1:0]                 req_valid_s;
    logic [1:0]                 rsp_ready_s;
    logic [1:0][DATA_WIDTH-1:0] req_a_s;
    logic [1:0][DATA_WIDTH-1:0] req_b_s;
    logic [1:0]                 req_signed_s;

    logic [1:0] elig_s;
    logic [1:0] cand_s;
    logic [1:0] grant_s;
    logic [1:0] req_ready_s;
    logic [1:0] req_hs_s;
    logic [1:0] rsp_valid_s;
    logic [1:0] rsp_hs_s;
    logic [1:0] fifo_wr_s;

    // Architectural state
    logic [1:0][CW-1:0]           cnt_q, cnt_d;
    logic                         last_grant_q, last_grant_d;
    logic                         mul_valid_q, mul_valid_d;
    logic [DATA_WIDTH-1:0]        mul_src0_q, mul_src0_d;
    logic [DATA_WIDTH-1:0]        mul_src1_q, mul_src1_d;
    logic                         mul_signed_q, mul_signed_d;
    logic                         mul_id_q, mul_id_d;
    logic [LATENCY-1:0]           sh_valid_q, sh_valid_d;
    logic [LATENCY-1:0]           sh_id_q, sh_id_d;
    logic [1:0][FIFO_DEPTH-1:0][PW-1:0] mem_q, mem_d;
    logic [1:0][AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [1:0][AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [1:0][CW-1:0]           occ_q, occ_d;

    assign req_valid_s  = {ch1.req_valid, ch0.req_valid};
    assign rsp_ready_s  = {ch1.rsp_ready, ch0.rsp_ready};
    assign req_a_s      = {ch1.req_a, ch0.req_a};
    assign req_b_s      = {ch1.req_b, ch0.req_b};
    assign req_signed_s = {ch1.req_signed, ch0.req_signed};

    assign ch0.req_ready = req_ready_s[0];
    assign ch1.req_ready = req_ready_s[1];
    assign ch0.rsp_valid = rsp_valid_s[0];
    assign ch1.rsp_valid = rsp_valid_s[1];
    assign ch0.rsp_data  = mem_q[0][rd_ptr_q[0]];
    assign ch1.rsp_data  = mem_q[1][rd_ptr_q[1]];

    assign mul_valid  = mul_valid_q;
    assign mul_src0   = mul_src0_q;
    assign mul_src1   = mul_src1_q;
    assign mul_signed = mul_signed_q;

    // The product leaving the shadow pipeline goes to the FIFO of its requester
    assign fifo_wr_s = {sh_valid_q[LATENCY-1] &  sh_id_q[LATENCY-1],
                        sh_valid_q[LATENCY-1] & ~sh_id_q[LATENCY-1]};

    // Round-robin grant among valid requesters that still hold a credit
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            // Eligibility uses the registered count, so a same-cycle pop does
            // not free a credit until the following cycle.
            elig_s[n]      = (cnt_q[n] < CNT_MAX);
            rsp_valid_s[n] = (occ_q[n] != CNT_ZERO);
        end
        cand_s = req_valid_s & elig_s;
        case (cand_s)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
            default: grant_s = 2'b00;
        endcase
        if (rst) begin
            req_ready_s = 2'b00;
        end else begin
            req_ready_s = grant_s;
        end
        req_hs_s = req_ready_s & req_valid_s;
        rsp_hs_s = rsp_valid_s & rsp_ready_s;
    end

    // Issue register, grant history and shadow pipeline next state
    always_comb begin
        mul_src0_d   = mul_src0_q;
        mul_src1_d   = mul_src1_q;
        mul_signed_d = mul_signed_q;
        mul_id_d     = mul_id_q;
        last_grant_d = last_grant_q;
        mul_valid_d  = |req_hs_s;
        if (req_hs_s[1]) begin
            mul_src0_d   = req_a_s[1];
            mul_src1_d   = req_b_s[1];
            mul_signed_d = req_signed_s[1];
            mul_id_d     = 1'b1;
            last_grant_d = 1'b1;
        end else if (req_hs_s[0]) begin
            mul_src0_d   = req_a_s[0];
            mul_src1_d   = req_b_s[0];
            mul_signed_d = req_signed_s[0];
            mul_id_d     = 1'b0;
            last_grant_d = 1'b0;
        end else begin
            mul_id_d     = mul_id_q;
        end
        // Stage 0 is fed from the issue register so the last stage lines up
        // with the cycle in which mul_res carries the matching product.
        sh_valid_d    = sh_valid_q;
        sh_id_d       = sh_id_q;
        sh_valid_d[0] = mul_valid_q;
        sh_id_d[0]    = mul_id_q;
        for (int i = 1; i < LATENCY; i++) begin
            sh_valid_d[i] = sh_valid_q[i-1];
            sh_id_d[i]    = sh_id_q[i-1];
        end
    end

    // Result FIFOs and credit counters next state
    always_comb begin
        mem_d = mem_q;
        for (int n = 0; n < 2; n++) begin
            if (fifo_wr_s[n]) begin
                mem_d[n][wr_ptr_q[n]] = mul_res;
                wr_ptr_d[n]           = wr_ptr_q[n] + PTR_ONE;
            end else begin
                wr_ptr_d[n]           = wr_ptr_q[n];
            end
            if (rsp_hs_s[n]) begin
                rd_ptr_d[n] = rd_ptr_q[n] + PTR_ONE;
            end else begin
                rd_ptr_d[n] = rd_ptr_q[n];
            end
            case ({fifo_wr_s[n], rsp_hs_s[n]})
                2'b10:   occ_d[n] = occ_q[n] + CNT_ONE;
                2'b01:   occ_d[n] = occ_q[n] - CNT_ONE;
                default: occ_d[n] = occ_q[n];
            endcase
            case ({req_hs_s[n], rsp_hs_s[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + CNT_ONE;
                2'b01:   cnt_d[n] = cnt_q[n] - CNT_ONE;
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    // State registers; reset discards in-flight work and queued results
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            mul_valid_q  <= 1'b0;
            mul_src0_q   <= '0;
            mul_src1_q   <= '0;
            mul_signed_q <= 1'b0;
            mul_id_q     <= 1'b0;
            sh_valid_q   <= '0;
            sh_id_q      <= '0;
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            mul_valid_q  <= mul_valid_d;
            mul_src0_q   <= mul_src0_d;
            mul_src1_q   <= mul_src1_d;
            mul_signed_q <= mul_signed_d;
            mul_id_q     <= mul_id_d;
            sh_valid_q   <= sh_valid_d;
            sh_id_q      <= sh_id_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
        end
    end
endmodule
